hazard_control_unit: RTL and testbench

HAZARD_CONTROL_UNIT -- requirements
Module: Hazard_Control_Unit

---
 rtl/hazard_control_unit.sv | 127 ++++++++++++
 tb/tb_hazard_control_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// Hazard control unit for a 5-stage pipeline with branches resolved in ID.
// It detects RAW hazards between the ID instruction and the ID/EX
// instruction, stalls the front end for one or two cycles, flushes IF/ID on
// taken branches and jumps, and keeps saturating stall/flush counters.
//
// Handshake-free block: all outputs are level signals valid every cycle.
// A stall cycle means pc_write_o=0, if_id_write_o=0, bubble_o=1 and
// if_id_flush_o=0. A stall always wins over a flush.
//
// dbg_state / dbg_rem expose the FSM state and the remaining-stall counter.
module hazard_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs_i,
    input  logic [4:0]  id_rt_i,
    input  logic        id_uses_rt_i,
    input  logic        id_branch_i,
    input  logic        id_branch_taken_i,
    input  logic        id_jmp_i,
    input  logic [4:0]  ex_write_reg_i,
    input  logic        ex_reg_write_i,
    input  logic        ex_mem_read_i,
    input  logic        clear_cnt_i,
    output logic        pc_write_o,
    output logic        if_id_write_o,
    output logic        bubble_o,
    output logic        if_id_flush_o,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o,
    output logic        dbg_state,
    output logic [1:0]  dbg_rem
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] rem;

    logic       match;
    logic [1:0] demand;

    // Register match and stall demand (0, 1 or 2 cycles) from the current ID/EX pair.
    always_comb begin
        match  = (ex_write_reg_i != 5'd0) &&
                 ((ex_write_reg_i == id_rs_i) ||
                  (id_uses_rt_i && (ex_write_reg_i == id_rt_i)));
        demand = 2'd0;
        if (match) begin
            if (id_branch_i && ex_mem_read_i) begin
                // Load result is not available until after MEM; branch compares in ID.
                demand = 2'd2;
            end else if (id_branch_i && ex_reg_write_i) begin
                // ALU result reaches ID one cycle too late for the branch compare.
                demand = 2'd1;
            end else if (!id_branch_i && ex_mem_read_i) begin
                // Classic load-use: one bubble, then forwarding covers it.
                demand = 2'd1;
            end
        end
    end

    // Pipeline control outputs; reset and any stall share the same safe values.
    always_comb begin
        pc_write_o    = 1'b0;
        if_id_write_o = 1'b0;
        bubble_o      = 1'b1;
        if_id_flush_o = 1'b0;
        if (reset && (state == RUN) && (demand == 2'd0)) begin
            pc_write_o    = 1'b1;
            if_id_write_o = 1'b1;
            bubble_o      = 1'b0;
            if_id_flush_o = id_jmp_i | (id_branch_i & id_branch_taken_i);
        end
    end

    // Stall sequencer: RUN evaluates demand, STALL counts down the remaining cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            rem   <= 2'd0;
        end else begin
            case (state)
                RUN: begin
                    if (demand != 2'd0) begin
                        rem   <= demand - 2'd1;
                        state <= (demand > 2'd1) ? STALL : RUN;
                    end
                end
                STALL: begin
                    rem <= (rem == 2'd0) ? 2'd0 : rem - 2'd1;
                    if (rem <= 2'd1) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                    rem   <= 2'd0;
                end
            endcase
        end
    end

    // Saturating performance counters; clear wins over increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_o <= 16'd0;
            flush_cnt_o <= 16'd0;
        end else if (clear_cnt_i) begin
            stall_cnt_o <= 16'd0;
            flush_cnt_o <= 16'd0;
        end else begin
            if (bubble_o && (stall_cnt_o != 16'hFFFF)) begin
                stall_cnt_o <= stall_cnt_o + 16'd1;
            end
            if (if_id_flush_o && (flush_cnt_o != 16'hFFFF)) begin
                flush_cnt_o <= flush_cnt_o + 16'd1;
            end
        end
    end

    assign dbg_state = state;
    assign dbg_rem   = rem;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed hazard scenarios, randomized traffic,
// mid-stall reset and counter saturation, checked by a scoreboard fed from a
// cycle-level reference model of the hazard rules.
module tb_hazard_control_unit;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       br;
    logic       taken;
    logic       jmp;
    logic [4:0] ewr;
    logic       erw;
    logic       emr;
    logic       clr;
    logic       rst_n;
  } stim_t;

  typedef struct packed {
    logic        pc;
    logic        ifw;
    logic        bub;
    logic        fl;
    logic [15:0] sc;
    logic [15:0] fc;
    logic        dst;
    logic [1:0]  drem;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]  id_rs_i = '0, id_rt_i = '0, ex_write_reg_i = '0;
  logic        id_uses_rt_i = 1'b0, id_branch_i = 1'b0, id_branch_taken_i = 1'b0;
  logic        id_jmp_i = 1'b0, ex_reg_write_i = 1'b0, ex_mem_read_i = 1'b0;
  logic        clear_cnt_i = 1'b0;
  logic        pc_write_o, if_id_write_o, bubble_o, if_id_flush_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;
  logic        dbg_state;
  logic [1:0]  dbg_rem;

  hazard_control_unit dut (
    .clk              (clk),
    .reset            (reset),
    .id_rs_i          (id_rs_i),
    .id_rt_i          (id_rt_i),
    .id_uses_rt_i     (id_uses_rt_i),
    .id_branch_i      (id_branch_i),
    .id_branch_taken_i(id_branch_taken_i),
    .id_jmp_i         (id_jmp_i),
    .ex_write_reg_i   (ex_write_reg_i),
    .ex_reg_write_i   (ex_reg_write_i),
    .ex_mem_read_i    (ex_mem_read_i),
    .clear_cnt_i      (clear_cnt_i),
    .pc_write_o       (pc_write_o),
    .if_id_write_o    (if_id_write_o),
    .bubble_o         (bubble_o),
    .if_id_flush_o    (if_id_flush_o),
    .stall_cnt_o      (stall_cnt_o),
    .flush_cnt_o      (flush_cnt_o),
    .dbg_state        (dbg_state),
    .dbg_rem          (dbg_rem)
  );

  // ---------------- reference model ----------------
  // pending = stall cycles still owed after the current one.
  int   pending = 0;
  int   m_stall = 0;
  int   m_flush = 0;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic int hazard_cycles(stim_t s);
    bit hit;
    hit = (s.ewr != 0) && ((s.ewr == s.rs) || (s.uses_rt && (s.ewr == s.rt)));
    if (!hit) return 0;
    if (s.br) return s.emr ? 2 : (s.erw ? 1 : 0);
    return s.emr ? 1 : 0;
  endfunction

  // Expected outputs for the cycle where s is applied; advances the model past the next edge.
  function automatic exp_t model_step(stim_t s);
    exp_t e;
    int   n;
    bit   stall;
    e = '0;
    if (!s.rst_n) begin
      pending = 0;
      m_stall = 0;
      m_flush = 0;
      e.bub   = 1'b1;
      return e;
    end
    e.dst  = (pending > 0);
    e.drem = 2'(pending);
    e.sc   = 16'(m_stall);
    e.fc   = 16'(m_flush);
    if (pending > 0) begin
      stall   = 1'b1;
      pending = pending - 1;
    end else begin
      n       = hazard_cycles(s);
      stall   = (n > 0);
      pending = stall ? n - 1 : 0;
    end
    e.pc  = !stall;
    e.ifw = !stall;
    e.bub = stall;
    e.fl  = !stall && (s.jmp || (s.br && s.taken));
    if (s.clr) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (e.bub && m_stall < 65535) m_stall++;
      if (e.fl && m_flush < 65535) m_flush++;
    end
    return e;
  endfunction

  // ---------------- scoreboard compare ----------------
  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  task automatic check_out(input exp_t e);
    cmp("pc_write", 16'(pc_write_o), 16'(e.pc));
    cmp("if_id_write", 16'(if_id_write_o), 16'(e.ifw));
    cmp("bubble", 16'(bubble_o), 16'(e.bub));
    cmp("if_id_flush", 16'(if_id_flush_o), 16'(e.fl));
    cmp("stall_cnt", stall_cnt_o, e.sc);
    cmp("flush_cnt", flush_cnt_o, e.fc);
    cmp("dbg_state", 16'(dbg_state), 16'(e.dst));
    cmp("dbg_rem", 16'(dbg_rem), 16'(e.drem));
  endtask

  // Monitor: one expected response per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) check_out(exp_q.pop_front());
  end

  // ---------------- driver ----------------
  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    id_rs_i           = s.rs;
    id_rt_i           = s.rt;
    id_uses_rt_i      = s.uses_rt;
    id_branch_i       = s.br;
    id_branch_taken_i = s.taken;
    id_jmp_i          = s.jmp;
    ex_write_reg_i    = s.ewr;
    ex_reg_write_i    = s.erw;
    ex_mem_read_i     = s.emr;
    clear_cnt_i       = s.clr;
    reset             = s.rst_n;
  endtask

  task automatic drive(input stim_t s);
    apply(s);
    exp_q.push_back(model_step(s));
    @(posedge clk);
    #1;
  endtask

  // Present a stimulus, confirm its first-cycle outputs, then pull reset mid-cycle.
  task automatic drive_then_reset(input stim_t s);
    exp_t e;
    stim_t r;
    apply(s);
    e = model_step(s);
    #1;
    check_out(e);
    r = s;
    r.rst_n = 1'b0;
    reset = 1'b0;
    exp_q.push_back(model_step(r));
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    stim_t s;
    @(posedge clk);
    #1;

    // Reset state
    s = idle();
    s.rst_n = 1'b0;
    s.jmp = 1'b1;
    repeat (3) drive(s);
    s = idle();
    repeat (2) drive(s);

    // Load-use: one stall cycle
    s = idle(); s.emr = 1; s.erw = 1; s.ewr = 5'd8; s.rs = 5'd8;
    drive(s);
    s = idle();
    repeat (2) drive(s);

    // Load feeding branch: two stalls, second held with inputs cleared
    s = idle(); s.emr = 1; s.erw = 1; s.ewr = 5'd9; s.rt = 5'd9; s.uses_rt = 1; s.br = 1; s.rs = 5'd2;
    drive(s);
    s = idle(); s.jmp = 1;
    drive(s);
    s = idle();
    drive(s);

    // rt match ignored when rt is not read
    s = idle(); s.emr = 1; s.ewr = 5'd9; s.rt = 5'd9; s.rs = 5'd1;
    drive(s);

    // ALU result feeding branch, then with r0 destination
    s = idle(); s.erw = 1; s.ewr = 5'd3; s.rs = 5'd3; s.br = 1;
    drive(s);
    s.ewr = 5'd0; s.rs = 5'd0;
    drive(s);
    s = idle();
    drive(s);

    // Stall beats jump flush, then jump alone flushes
    s = idle(); s.emr = 1; s.ewr = 5'd8; s.rs = 5'd8; s.jmp = 1;
    drive(s);
    s = idle(); s.jmp = 1;
    drive(s);
    s = idle(); s.br = 1; s.taken = 1;
    drive(s);
    s = idle(); s.br = 1; s.taken = 0;
    drive(s);

    // Back-to-back hazards with no gap cycle
    s = idle(); s.emr = 1; s.ewr = 5'd4; s.rs = 5'd4; s.br = 1;
    drive(s); drive(s); drive(s);
    s = idle();
    drive(s);

    // Counter clear
    s = idle(); s.clr = 1;
    drive(s);
    s = idle();
    drive(s);

    // Reset asserted in the first cycle of a two-cycle stall
    s = idle(); s.emr = 1; s.ewr = 5'd5; s.rs = 5'd5; s.br = 1;
    drive_then_reset(s);
    s = idle();
    s.rst_n = 1'b0;
    drive(s);
    s = idle();
    repeat (2) drive(s);

    // Randomized traffic over a small register range to hit matches often
    for (int i = 0; i < 3000; i++) begin
      s.rs      = 5'($urandom_range(0, 3));
      s.rt      = 5'($urandom_range(0, 3));
      s.ewr     = 5'($urandom_range(0, 3));
      s.uses_rt = 1'($urandom_range(0, 1));
      s.br      = 1'($urandom_range(0, 1));
      s.taken   = 1'($urandom_range(0, 1));
      s.jmp     = ($urandom_range(0, 3) == 0);
      s.erw     = 1'($urandom_range(0, 1));
      s.emr     = 1'($urandom_range(0, 1));
      s.clr     = ($urandom_range(0, 19) == 0);
      s.rst_n   = ($urandom_range(0, 99) != 0);
      drive(s);
    end
    s = idle();
    drive(s);

    // Saturation: continuous load-use stalls, then clear while stalling
    s = idle(); s.emr = 1; s.ewr = 5'd8; s.rs = 5'd8;
    for (int i = 0; i < 65540; i++) drive(s);
    s.clr = 1;
    drive(s);
    s.clr = 0;
    drive(s);
    s = idle();
    drive(s);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
